// File: rtl/core_net_pkg.sv
// ---------------------------------------------------------------------------
// core_net_pkg
// Shared constants and types for the multicore Taylor-series network.
//   DW            result word width (signed)
//   SW            input sample width
//   ENW           width of each core's out_en code
//   OUT_EN_VALID  the only out_en code that carries a result
//   NCORES        number of processing cores
//   IW            core index width (2^IW >= NCORES)
//   DEPTH         default output FIFO depth
//   result_tag_t  {core index, word} as carried through the collector
// ---------------------------------------------------------------------------
package core_net_pkg;

  localparam int DW     = 28;
  localparam int SW     = 19;
  localparam int ENW    = 4;
  localparam logic [ENW-1:0] OUT_EN_VALID = 4'd1;
  localparam int NCORES = 22;
  localparam int IW     = 5;
  localparam int DEPTH  = 16;

  typedef struct packed {
    logic [IW-1:0] core;
    logic [DW-1:0] word;
  } result_tag_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// ---------------------------------------------------------------------------
// sync_fifo_sa
// Show-ahead synchronous FIFO: the head entry is visible on data_o without
// a read strobe; pop_i advances to the next entry.
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i (accepted when not full, or full and popping)
//   push_data_i   W-bit entry
//   pop_i         drop the head entry (ignored when empty)
//   data_o        head entry, forced to 0 while empty
//   empty_o       no entries stored
//   full_o        DEPTH entries stored
//   level_o       occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo_sa #(
  parameter int W     = 28,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LW'(DEPTH));
  assign level_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Storage has no reset; the empty flag masks whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/core_out_collector.sv
// ---------------------------------------------------------------------------
// core_out_collector
// Captures result words from NCORES cores, arbitrates round-robin and
// queues them in a show-ahead FIFO behind one valid/ready output.
//   clk, rst   clock, asynchronous active-high reset
//   out_en     per-core codes, core k at [k*ENW +: ENW]; code 1 = result
//   io_out     per-core results, core k at [k*DW +: DW]
//   m_data     head-of-FIFO word
//   m_core     core index of head word (only with COLLECT_TAG_EN)
//   m_valid    FIFO not empty
//   m_ready    consumer accepts the head word
//   ovf        sticky per-core overflow (a word was dropped)
//   ovf_clr    clear all ovf bits
//   level      FIFO occupancy 0..DEPTH
// Build option: define COLLECT_TAG_EN to add m_core and store the core
// index alongside each word.
// ---------------------------------------------------------------------------
module core_out_collector
  import core_net_pkg::*;
#(
  parameter int NCORES = core_net_pkg::NCORES,
  parameter int DW     = core_net_pkg::DW,
  parameter int ENW    = core_net_pkg::ENW,
  parameter int DEPTH  = core_net_pkg::DEPTH,
  parameter int IW     = core_net_pkg::IW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORES*ENW-1:0] out_en,
  input  logic [NCORES*DW-1:0]  io_out,
  output logic [DW-1:0]         m_data,
`ifdef COLLECT_TAG_EN
  output logic [IW-1:0]         m_core,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [NCORES-1:0]     ovf,
  input  logic                  ovf_clr,
  output logic [IW:0]           level
);

`ifdef COLLECT_TAG_EN
  localparam int FW = IW + DW;
`else
  localparam int FW = DW;
`endif

  logic [NCORES-1:0]    present, grant_oh, ovf_set;
  logic [NCORES-1:0]    pend_q, pend_d, ovf_q, ovf_d;
  logic [IW-1:0]        rr_q, rr_d, grant_idx;
  logic [IW:0]          cand;
  logic                 grant_vld, pop, can_grant, fifo_empty, fifo_full;
  logic [NCORES*DW-1:0] hold_flat;
  logic [DW-1:0]        grant_word;
  logic [FW-1:0]        push_data, head_data;

  // Per-core capture: a single hold register plus pending flag. A new word
  // is latched unless it would overwrite a held word that is not leaving
  // this cycle; in that case it is dropped and flagged as overflow.
  generate
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
      logic [DW-1:0] hold_q;

      assign present[gi]  = (out_en[gi*ENW +: ENW] == ENW'(OUT_EN_VALID));
      assign grant_oh[gi] = grant_vld && (grant_idx == IW'(gi));
      assign ovf_set[gi]  = present[gi] && pend_q[gi] && !grant_oh[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q <= '0;
        end else if (present[gi] && !ovf_set[gi]) begin
          hold_q <= io_out[gi*DW +: DW];
        end
      end

      assign hold_flat[gi*DW +: DW] = hold_q;
    end
  endgenerate

  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign can_grant = !fifo_full || pop;

  // Round-robin search starting one past the last granted core.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NCORES; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NCORES)) cand = cand - (IW+1)'(NCORES);
      if (can_grant && !grant_vld && pend_q[cand[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (grant_oh[k]) grant_word = hold_flat[k*DW +: DW];
    end
  end

  // A core granted and presenting in the same cycle stays pending with
  // its new word.
  assign pend_d = present | (pend_q & ~grant_oh);
  // An overflow in the clearing cycle keeps its bit set.
  assign ovf_d  = ovf_set | (ovf_q & ~{NCORES{ovf_clr}});
  assign rr_d   = grant_vld ? grant_idx : rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
    end
  end

  assign ovf = ovf_q;

`ifdef COLLECT_TAG_EN
  assign push_data = {grant_idx, grant_word};
  assign m_core    = head_data[FW-1:DW];
`else
  assign push_data = grant_word;
`endif
  assign m_data = head_data[DW-1:0];

  sync_fifo_sa #(
    .W     (FW),
    .DEPTH (DEPTH),
    .LW    (IW + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant_vld),
    .push_data_i (push_data),
    .pop_i       (pop),
    .data_o      (head_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .level_o     (level)
  );

endmodule

// File: tb/tb_core_out_collector.sv
module tb_core_out_collector;
  import core_net_pkg::*;

  localparam int NC = core_net_pkg::NCORES;
  localparam int LW = IW + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC*ENW-1:0] out_en = '0;
  logic [NC*DW-1:0]  io_out = '0;
  logic [DW-1:0]     m_data;
`ifdef COLLECT_TAG_EN
  logic [IW-1:0]     m_core;
`endif
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [NC-1:0]     ovf;
  logic              ovf_clr = 1'b0;
  logic [LW-1:0]     level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: per-core slot, last winner, output queue.
  bit            mp [NC];
  logic [DW-1:0] mh [NC];
  int            mrr;
  logic [NC-1:0] movf;
  result_tag_t   mq [$];

  always #5 clk = ~clk;

  core_out_collector dut (
    .clk     (clk),
    .rst     (rst),
    .out_en  (out_en),
    .io_out  (io_out),
    .m_data  (m_data),
`ifdef COLLECT_TAG_EN
    .m_core  (m_core),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .level   (level)
  );

  task automatic model_reset();
    mq.delete();
    mrr  = 0;
    movf = '0;
    for (int k = 0; k < NC; k++) begin
      mp[k] = 1'b0;
      mh[k] = '0;
    end
  endtask

  // One clock edge of the collector, from the current (stable) inputs.
  task automatic model_step();
    bit popd, can;
    int g;
    result_tag_t t;
    popd = (mq.size() > 0) && m_ready;
    can  = (mq.size() < DEPTH) || popd;
    g    = -1;
    if (can) begin
      for (int s = 1; s <= NC; s++) begin
        if (g < 0 && mp[(mrr + s) % NC]) g = (mrr + s) % NC;
      end
    end
    if (ovf_clr) movf = '0;
    if (popd) void'(mq.pop_front());
    if (g >= 0) begin
      t.core = IW'(g);
      t.word = mh[g];
      mq.push_back(t);
      mp[g] = 1'b0;
      mrr   = g;
    end
    for (int k = 0; k < NC; k++) begin
      if (out_en[k*ENW +: ENW] == 4'd1) begin
        if (mp[k]) movf[k] = 1'b1;
        else begin
          mp[k] = 1'b1;
          mh[k] = io_out[k*DW +: DW];
        end
      end
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_core(input int k, input logic [ENW-1:0] code, input logic [DW-1:0] d);
    out_en[k*ENW +: ENW] = code;
    io_out[k*DW +: DW]   = d;
  endtask

  task automatic clear_inputs();
    out_en  = '0;
    io_out  = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_tests++;
    if (ovf !== '0) begin n_fail++; $display("FAIL reset_ovf: got %h want 0", ovf); end
    n_tests++;
    if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", m_data); end
    do_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    v = DW'(-12345);
    do_reset();
    m_ready = 1'b1;
    set_core(3, 4'd1, v);
    tick();
    clear_inputs();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %b want 0", m_valid); end
    tick();
    n_tests++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", m_valid); end
    n_tests++;
    if (m_data !== v) begin n_fail++; $display("FAIL single_data: got %0d want -12345", $signed(m_data)); end
    n_tests++;
    if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level1: got %0d want 1", level); end
`ifdef COLLECT_TAG_EN
    n_tests++;
    if (m_core !== IW'(3)) begin n_fail++; $display("FAIL single_core: got %0d want 3", m_core); end
`endif
    tick();
    n_tests++;
    if (m_valid !== 1'b0 || level !== '0) begin
      n_fail++; $display("FAIL single_drain: got valid %b level %0d want 0 0", m_valid, level);
    end
    $display("[TB] single core 3 word %0d", $signed(v));
  endtask

  task automatic test_simultaneous();
    int            cores [3];
    logic [DW-1:0] data  [3];
    cores = '{5, 21, 0};
    data  = '{DW'(-200), DW'(300), DW'(100)};
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) set_core(cores[i], 4'd1, data[i]);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== data[i]) begin
        n_fail++;
        $display("FAIL simul_order%0d: got valid %b data %0d want 1 %0d", i, m_valid, $signed(m_data), $signed(data[i]));
      end
`ifdef COLLECT_TAG_EN
      n_tests++;
      if (m_core !== IW'(cores[i])) begin n_fail++; $display("FAIL simul_core%0d: got %0d want %0d", i, m_core, cores[i]); end
`endif
      $display("[TB] simultaneous out %0d core %0d", i, cores[i]);
    end
    tick();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b want 0", m_valid); end
  endtask

  task automatic test_code_filter();
    logic [ENW-1:0] codes [3];
    codes = '{4'd0, 4'd2, 4'd15};
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_core(7, codes[i], DW'(777));
      tick();
      clear_inputs();
      tick();
      tick();
      n_tests++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL filter_code%0d: got valid %b want 0", codes[i], m_valid); end
      $display("[TB] filter code %0d ignored", codes[i]);
    end
    set_core(7, 4'd1, DW'(777));
    tick();
    clear_inputs();
    tick();
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== DW'(777)) begin
      n_fail++; $display("FAIL filter_code1: got valid %b data %0d want 1 777", m_valid, m_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [20];
    int n;
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 20; k++) set_core(k, 4'd1, DW'(1000 + k));
    tick();
    clear_inputs();
    repeat (24) tick();
    n_tests++;
    if (level !== LW'(16)) begin n_fail++; $display("FAIL bp_level: got %0d want 16", level); end
    n_tests++;
    if (ovf !== '0) begin n_fail++; $display("FAIL bp_ovf: got %h want 0", ovf); end
    m_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 20; cyc++) begin
      if (m_valid) begin got[n] = m_data; n++; end
      tick();
    end
    n_tests++;
    if (n != 20) begin n_fail++; $display("FAIL bp_count: got %0d want 20", n); end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (got[i] !== DW'(1000 + ((i + 1) % 20))) begin
        n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], 1000 + ((i + 1) % 20));
      end
    end
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", level); end
    $display("[TB] backpressure drained %0d words", n);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] got [17];
    logic [NC-1:0] exp_ovf;
    int n;
    exp_ovf    = '0;
    exp_ovf[2] = 1'b1;
    do_reset();
    m_ready = 1'b0;
    for (int k = 4; k < 20; k++) set_core(k, 4'd1, DW'(500 + k));
    tick();
    clear_inputs();
    repeat (20) tick();
    n_tests++;
    if (level !== LW'(16)) begin n_fail++; $display("FAIL ovf_full: got %0d want 16", level); end
    set_core(2, 4'd1, DW'(11));
    tick();
    set_core(2, 4'd1, DW'(22));
    tick();
    clear_inputs();
    n_tests++;
    if (ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_set: got %h want %h", ovf, exp_ovf); end
    m_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 17; cyc++) begin
      if (m_valid) begin got[n] = m_data; n++; end
      tick();
    end
    n_tests++;
    if (n != 17 || m_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_count: got %0d valid %b want 17 0", n, m_valid); end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (got[i] !== ((i < 16) ? DW'(504 + i) : DW'(11))) begin
        n_fail++; $display("FAIL ovf_word%0d: got %0d want %0d", i, got[i], (i < 16) ? 504 + i : 11);
      end
    end
    n_tests++;
    if (ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %h want %h", ovf, exp_ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== '0) begin n_fail++; $display("FAIL ovf_clr: got %h want 0", ovf); end
    $display("[TB] overflow on core 2 checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) set_core(k, 4'd1, DW'(k + 1));
    tick();
    clear_inputs();
    repeat (8) tick();
    n_tests++;
    if (level !== LW'(5)) begin n_fail++; $display("FAIL rmid_level: got %0d want 5", level); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || level !== '0) begin
      n_fail++; $display("FAIL rmid_async: got valid %b level %0d want 0 0", m_valid, level);
    end
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale%0d: got valid %b data %0d want 0", i, m_valid, m_data); end
    end
    $display("[TB] mid-stream reset checked");
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NC; k++) begin
        r = $urandom_range(0, 63);
        if (r == 0) set_core(k, 4'd1, DW'($urandom));
        else if (r < 4) set_core(k, ENW'($urandom_range(2, 15)), DW'($urandom));
        else set_core(k, 4'd0, DW'($urandom));
      end
      m_ready = ($urandom_range(0, 99) < ((cyc < 300) ? 25 : 75));
      ovf_clr = ($urandom_range(0, 29) == 0);
      tick();
      n_tests++;
      if (m_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, m_valid, mq.size() != 0); end
      n_tests++;
      if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL rand_level@%0d: got %0d want %0d", cyc, level, mq.size()); end
      n_tests++;
      if (m_data !== ((mq.size() != 0) ? mq[0].word : '0)) begin
        n_fail++; $display("FAIL rand_data@%0d: got %h want %h", cyc, m_data, (mq.size() != 0) ? mq[0].word : '0);
      end
`ifdef COLLECT_TAG_EN
      n_tests++;
      if (m_core !== ((mq.size() != 0) ? mq[0].core : '0)) begin
        n_fail++; $display("FAIL rand_core@%0d: got %0d want %0d", cyc, m_core, (mq.size() != 0) ? mq[0].core : '0);
      end
`endif
      n_tests++;
      if (ovf !== movf) begin n_fail++; $display("FAIL rand_ovf@%0d: got %h want %h", cyc, ovf, movf); end
    end
    clear_inputs();
    $display("[TB] random run done, queue depth %0d", mq.size());
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_code_filter();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_out_collector.md
Name: core_out_collector

Overview:
- Gathers result words from the NCORES processing cores of the multicore Taylor-series network into one ordered stream.
- Each core pulses its 4-bit out_en code with a 28-bit signed result. The block captures every valid result, arbitrates round-robin and buffers the words in a FIFO.
- A single valid/ready output feeds the host/UART side, replacing the per-core output taps the bench uses today.

Parameters:
- NCORES, 22, number of core result ports
- DW, 28, result word width (signed)
- ENW, 4, width of each core's out_en code
- DEPTH, 16, output FIFO depth; power of two, >=2
- IW, 5, core index width; must satisfy 2^IW >= NCORES

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- out_en  in  NCORES*ENW  per-core enable codes; core k occupies bits [k*ENW +: ENW]
- io_out  in  NCORES*DW  per-core results; core k occupies bits [k*DW +: DW]
- m_data  out  DW  head-of-FIFO result word
- m_core  out  IW  core index of the head word (only with COLLECT_TAG_EN)
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts the word when m_valid && m_ready
- ovf  out  NCORES  sticky per-core overflow flags
- ovf_clr  in  1  synchronous clear of all ovf bits
- level  out  IW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1): all pending flags 0, FIFO empty, m_valid=0, m_data=0, m_core=0, ovf=0, level=0, round-robin pointer=0.
- Capture: a core presents a result when its code equals exactly 4'd1. Other codes, 0 and 2..15 included, are ignored.
- A presented result is latched into that core's hold register at the edge and pend[k] is set.
- Overflow: if pend[k]=1, is not granted in the same cycle, and the core presents again, the new word is dropped and ovf[k] is set. The held word is kept.
- Grant and new present on the same core in the same cycle: the held word goes to the FIFO, the new word is latched, pend stays 1, no overflow.
- Arbiter: one grant per cycle, only when the FIFO is not full, or when it is full but popped this cycle.
  - The search starts at index rr+1 (mod NCORES) and takes the first pending core.
  - On grant: rr becomes the granted index, pend clears, and {index, word} is written to the FIFO.
- Latency: present at edge t -> pend at t -> FIFO write at edge t+1 -> m_valid high after edge t+1, i.e. 2 edges from present to output.
- FIFO: show-ahead; m_data/m_core show the head combinationally from storage. Pop on m_valid && m_ready.
- Simultaneous push and pop at full is allowed, and level is unchanged. Push when full without a pop does not happen, because the arbiter stalls.
- Pointers wrap modulo DEPTH.
- Ordering: words from the same core leave in capture order. Across cores, order follows grant order.
- ovf_clr clears ovf in the same cycle. A simultaneous overflow event wins, so the bit stays set.
- Mid-operation reset discards all held and buffered words. Output deasserts immediately (asynchronous).

Optional Feature:
- COLLECT_TAG_EN defined: the m_core port exists and the FIFO stores IW+DW bits per entry.
- COLLECT_TAG_EN undefined: m_core is absent, the FIFO stores DW bits, and arbitration is unchanged.

Decomposition:
- Package core_net_pkg holds:
  - DW=28
  - sample width 19
  - ENW=4
  - OUT_EN_VALID=4'd1
  - NCORES=22
  - a result-tag struct {core index, word}
- One natural sub-module, sync_fifo_sa: parameterised show-ahead FIFO with level output.
- The round-robin arbiter stays inline.

Test Plan:
- Single core: core 3 presents code 1 with data -12345 and m_ready=1 -> m_valid rises 2 edges later with m_data=-12345, m_core=3, held 1 cycle, level back to 0.
- Simultaneous: cores 0, 5 and 21 present at the same edge, rr=0 -> output order 5, 21, 0 on consecutive cycles. Data values 100, -200, 300 match.
- Code filter: core 7 presents codes 0, 2 and 15 -> no capture, m_valid stays 0. Code 1 -> captured.
- Backpressure: m_ready=0 while 20 cores present once -> level saturates at 16 and 4 cores stay pending with ovf=0. Set m_ready=1 -> all 20 words emerge, none lost.
- Overflow: m_ready=0, FIFO full, core 2 presents 11 then 22 -> ovf[2]=1. After drain, 11 appears and 22 never does. ovf_clr -> ovf=0.
- Reset mid-stream: 5 words buffered, pulse rst -> m_valid=0 and level=0 without a clock edge. No stale words appear after release.
